cpu: RTL and testbench
======================

CPU -- requirements
Module: cpu

Interface
REQ-001 The block SHALL have one clock and one reset: reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 data_in  input  16  read data from the bus mux (memory 0x000-0x6ff, keypad 0x900-0x901); sampled at the clk edge.
REQ-005 data_out  output  16  write data; equals accumulator A at all times.
REQ-006 address  output  12  bus address; combinational from state.
REQ-007 memwt  output  1  write strobe; combinational, high only in EXEC of STA.
REQ-008 pc  output  16  program counter, zero-extended from 12 bits.
REQ-009 No parameters; data width is 16 bits and address width is 12 bits.

Function
REQ-010 Registers SHALL be: pc[11:0], ir[15:0], A[15:0], halted flag, and a 1-bit state (FETCH, EXEC).
REQ-011 Instruction format SHALL be opcode = ir[15:12] and operand k = ir[11:0]; sext(k) sign-extends bit 11 to 16 bits.
REQ-012 In FETCH, address SHALL equal pc, memwt SHALL be 0, and at the edge: ir <= data_in, pc <= pc+1 (mod 4096), state <= EXEC.
REQ-013 In EXEC, address SHALL equal k, and at the edge the opcode SHALL execute and state <= FETCH; each instruction takes exactly 2 clocks.
REQ-014 Memory-operand opcodes SHALL be: 0 LDA A<=M[k]; 1 STA M[k]<=A (memwt=1); 2 ADD A<=A+M[k]; 3 SUB A<=A-M[k]; 4 AND A<=A&M[k]; 8 OR A<=A|M[k]; 9 XOR A<=A^M[k].
REQ-015 Register and control opcodes SHALL be: 5 JMPR pc<=pc+sext(k), using the already-incremented pc; 6 JZ pc<=k if A==0; E JNZ pc<=k if A!=0; D JMP pc<=k; 7 LDI A<=sext(k).
REQ-016 Shift and halt opcodes SHALL be: A NOT A<=~A; B SHL A<=A<<1; C SHR A<=A>>1 (logical); F HLT sets halted.
REQ-017 Arithmetic SHALL be 16-bit modulo 2^16; there are no flags or carry; pc arithmetic SHALL be modulo 4096.
REQ-018 Non-memory opcodes SHALL still drive address=k in EXEC and SHALL ignore data_in.
REQ-019 While halted, state SHALL stay FETCH, pc/A/ir SHALL be frozen, and memwt SHALL be 0; only rst clears halted.
REQ-020 memwt SHALL never be high in FETCH, during rst, or while halted.
REQ-021 The cpu SHALL be unaware of the memory map; decoding of the 0xb00 seven-segment register and the keypad is external.

Reset
REQ-022 With rst high at a clk edge: pc=0, A=0, ir=0, halted=0, state=FETCH; rst has priority over any in-flight instruction.
REQ-023 After reset the outputs SHALL be: address=0x000, memwt=0, data_out=0x0000, pc=0x0000.
REQ-024 State before the first reset is don't-care; no initial-value dependence is permitted.

Verification
REQ-025 Reset: rst=1 for one edge in any state -> pc=0, address=0x000, memwt=0, data_out=0x0000.
REQ-026 Program M[0]=0x7e80, M[1]=0x5ffe: after 2 clocks A=0xfe80; after 4 clocks pc=0; the pair loops forever with A constant.
REQ-027 M[0x10]=3, M[0x11]=4, program 0x0010, 0x2011, 0x1012 -> on the 6th clock (STA EXEC): memwt=1, address=0x012, data_out=0x0007.
REQ-028 JZ/JNZ: program LDI 0 (0x7000) then JZ 0x020 (0x6020) -> pc=0x020. With LDI 1 (0x7001) instead -> pc=0x002.
REQ-029 STA 0xb00 (0x1b00) with A=0x1234 -> memwt=1, address=0xb00, data_out=0x1234 for exactly one EXEC cycle.
REQ-030 HLT (0xf000) -> pc, A and memwt frozen for 10+ clocks. Then rst asserted in the EXEC of a following STA -> no memwt pulse after the edge, and pc=0.

Source files
------------

// File: rtl/cpu_if.sv
// cpu_if: cpu memory/IO bus (read data in, write data/address/strobe out)
interface cpu_if;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic [11:0] address;
  logic memwt;
  modport master(input data_in, output data_out, address, memwt);
  modport slave(output data_in, input data_out, address, memwt);
endinterface

// File: rtl/cpu.sv
// cpu: two-cycle (FETCH/EXEC) 16-bit accumulator cpu with 12-bit address space
module cpu (
  input  logic        clk,
  input  logic        rst,
  cpu_if.master       bus,
  output logic [15:0] pc
);
  typedef enum logic {FETCH, EXEC} state_t;
  state_t state;
  logic [11:0] pc_r;
  logic [15:0] ir, a, a_nxt;
  logic halted;
  logic [3:0] op;
  logic [11:0] k;
  logic [15:0] sk;
  logic [15:0] m;
  assign op = ir[15:12];
  assign k = ir[11:0];
  assign sk = {{4{k[11]}}, k};
  assign m = bus.data_in;
  assign pc = {4'h0, pc_r};
  assign bus.data_out = a;
  assign bus.address = state == EXEC ? k : pc_r;
  assign bus.memwt = state == EXEC && op == 4'h1 && !rst && !halted;
  always_comb begin
    a_nxt = a;
    case (op)
      4'h0: a_nxt = m;
      4'h2: a_nxt = a + m;
      4'h3: a_nxt = a - m;
      4'h4: a_nxt = a & m;
      4'h7: a_nxt = sk;
      4'h8: a_nxt = a | m;
      4'h9: a_nxt = a ^ m;
      4'ha: a_nxt = ~a;
      4'hb: a_nxt = a << 1;
      4'hc: a_nxt = a >> 1;
      default: a_nxt = a;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r <= '0;
      ir <= '0;
      a <= '0;
      halted <= 1'b0;
      state <= FETCH;
    end else if (!halted) begin
      if (state == FETCH) begin
        ir <= bus.data_in;
        pc_r <= pc_r + 12'd1;
        state <= EXEC;
      end else begin
        state <= FETCH;
        a <= a_nxt;
        halted <= op == 4'hf;
        // JMPR offsets from the pc already advanced past this instruction
        pc_r <= op == 4'h5 ? pc_r + k :
                op == 4'hd || (op == 4'h6 && a == '0) || (op == 4'he && a != '0) ? k : pc_r;
      end
    end
  end
endmodule

// File: tb/tb_cpu.sv
// tb_cpu: directed ISA scenarios plus random programs checked against an instruction-level model
module tb_cpu;
  logic clk = 0;
  logic rst = 1;
  logic [15:0] pc;
  logic [15:0] mem [4096];
  logic [15:0] mm [4096];
  int total = 0;
  int bad = 0;
  cpu_if bus ();
  cpu dut (.clk(clk), .rst(rst), .bus(bus), .pc(pc));
  always #5 clk = ~clk;
  assign bus.data_in = mem[bus.address];
  always @(posedge clk) if (bus.memwt) mem[bus.address] <= bus.data_out;

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
  endtask

  task automatic do_reset();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic clocks(int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
    rst = 0;
    clocks(7);
    rst = 1;
    #1;
    total++; if (bus.memwt !== 1'b0) begin bad++; $display("FAIL rst_memwt_comb got=%0h want=0", bus.memwt); end
    @(posedge clk); #1;
    total++; if (pc !== 16'h0000) begin bad++; $display("FAIL reset_pc got=%h want=0000", pc); end
    total++; if (bus.address !== 12'h000) begin bad++; $display("FAIL reset_address got=%h want=000", bus.address); end
    total++; if (bus.memwt !== 1'b0) begin bad++; $display("FAIL reset_memwt got=%0h want=0", bus.memwt); end
    total++; if (bus.data_out !== 16'h0000) begin bad++; $display("FAIL reset_data_out got=%h want=0000", bus.data_out); end
    rst = 0;
  endtask

  task automatic test_ldi_jmpr();
    clear_mem();
    mem[0] = 16'h7e80;
    mem[1] = 16'h5ffe;
    do_reset();
    clocks(2);
    total++; if (bus.data_out !== 16'hfe80) begin bad++; $display("FAIL ldi_a got=%h want=fe80", bus.data_out); end
    clocks(2);
    total++; if (pc !== 16'h0000) begin bad++; $display("FAIL jmpr_pc got=%h want=0000", pc); end
    clocks(12);
    total++; if (pc !== 16'h0000 || bus.data_out !== 16'hfe80) begin
      bad++; $display("FAIL loop_steady pc=%h a=%h want pc=0000 a=fe80", pc, bus.data_out);
    end
  endtask

  task automatic test_add_sta();
    clear_mem();
    mem[0] = 16'h0010; mem[1] = 16'h2011; mem[2] = 16'h1012;
    mem[16'h10] = 16'd3; mem[16'h11] = 16'd4;
    do_reset();
    clocks(5);
    total++; if (bus.memwt !== 1'b1 || bus.address !== 12'h012 || bus.data_out !== 16'h0007) begin
      bad++; $display("FAIL sta_exec memwt=%0h addr=%h data=%h want 1/012/0007", bus.memwt, bus.address, bus.data_out);
    end
    clocks(1);
    total++; if (mem[12'h012] !== 16'h0007) begin bad++; $display("FAIL sta_store got=%h want=0007", mem[12'h012]); end
    total++; if (bus.memwt !== 1'b0) begin bad++; $display("FAIL fetch_memwt got=%0h want=0", bus.memwt); end
  endtask

  task automatic test_jz_jnz();
    clear_mem();
    mem[0] = 16'h7000; mem[1] = 16'h6020;
    do_reset();
    clocks(4);
    total++; if (pc !== 16'h0020) begin bad++; $display("FAIL jz_taken got=%h want=0020", pc); end
    mem[0] = 16'h7001;
    do_reset();
    clocks(4);
    total++; if (pc !== 16'h0002) begin bad++; $display("FAIL jz_not_taken got=%h want=0002", pc); end
    mem[1] = 16'he020;
    do_reset();
    clocks(4);
    total++; if (pc !== 16'h0020) begin bad++; $display("FAIL jnz_taken got=%h want=0020", pc); end
  endtask

  task automatic test_sta_io();
    int pulses = 0;
    clear_mem();
    mem[0] = 16'h0030; mem[1] = 16'h1b00; mem[2] = 16'hd002;
    mem[16'h30] = 16'h1234;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      if (bus.memwt === 1'b1) begin
        pulses++;
        total++; if (bus.address !== 12'hb00 || bus.data_out !== 16'h1234) begin
          bad++; $display("FAIL io_write addr=%h data=%h want b00/1234", bus.address, bus.data_out);
        end
      end
      clocks(1);
    end
    total++; if (pulses != 1) begin bad++; $display("FAIL io_pulse_count got=%0d want=1", pulses); end
  endtask

  task automatic test_halt();
    logic [15:0] hp, ha;
    clear_mem();
    mem[0] = 16'h7005; mem[1] = 16'hf000; mem[2] = 16'h1040; mem[3] = 16'h7777;
    do_reset();
    clocks(4);
    hp = pc; ha = bus.data_out;
    total++; if (hp !== 16'h0002 || ha !== 16'h0005) begin
      bad++; $display("FAIL halt_entry pc=%h a=%h want 0002/0005", hp, ha);
    end
    for (int i = 0; i < 12; i++) begin
      clocks(1);
      total++; if (pc !== hp || bus.data_out !== ha || bus.memwt !== 1'b0) begin
        bad++; $display("FAIL halt_frozen pc=%h a=%h memwt=%0h", pc, bus.data_out, bus.memwt);
      end
    end
    clear_mem();
    mem[0] = 16'h1040;
    mem[16'h40] = 16'hbeef;
    do_reset();
    clocks(1);
    total++; if (bus.memwt !== 1'b1) begin bad++; $display("FAIL sta_pre_rst memwt got=%0h want=1", bus.memwt); end
    rst = 1;
    #1;
    total++; if (bus.memwt !== 1'b0) begin bad++; $display("FAIL sta_rst_memwt got=%0h want=0", bus.memwt); end
    @(posedge clk); #1;
    total++; if (pc !== 16'h0000 || mem[16'h40] !== 16'hbeef) begin
      bad++; $display("FAIL sta_rst_abort pc=%h m=%h want 0000/beef", pc, mem[16'h40]);
    end
    rst = 0;
  endtask

  task automatic test_random(int prog, int steps);
    logic [11:0] mpc;
    logic [15:0] ma, ir, s, x;
    logic [3:0] op;
    logic [11:0] k;
    for (int p = 0; p < prog; p++) begin
      for (int i = 0; i < 4096; i++) begin
        x = 16'($urandom);
        if (x[15:12] == 4'hf) x[15:12] = 4'hd;
        mem[i] = x;
        mm[i] = x;
      end
      mpc = 0; ma = 0;
      do_reset();
      for (int n = 0; n < steps; n++) begin
        total++; if (bus.address !== mpc || bus.memwt !== 1'b0) begin
          bad++; $display("FAIL rnd_fetch n=%0d addr=%h memwt=%0h want %h/0", n, bus.address, bus.memwt, mpc);
        end
        ir = mm[mpc];
        op = ir[15:12];
        k = ir[11:0];
        s = 16'(signed'(k));
        mpc = mpc + 12'd1;
        clocks(1);
        total++; if (bus.address !== k || bus.memwt !== (op == 4'h1)) begin
          bad++; $display("FAIL rnd_exec n=%0d ir=%h addr=%h memwt=%0h", n, ir, bus.address, bus.memwt);
        end
        case (op)
          4'h0: ma = mm[k];
          4'h1: mm[k] = ma;
          4'h2: ma = ma + mm[k];
          4'h3: ma = ma - mm[k];
          4'h4: ma = ma & mm[k];
          4'h5: mpc = 12'((32'(mpc) + 32'(signed'(s))) % 4096);
          4'h6: if (ma == 0) mpc = k;
          4'h7: ma = s;
          4'h8: ma = ma | mm[k];
          4'h9: ma = ma ^ mm[k];
          4'ha: ma = ~ma;
          4'hb: ma = ma * 2;
          4'hc: ma = ma / 2;
          4'hd: mpc = k;
          4'he: if (ma != 0) mpc = k;
          default: ;
        endcase
        clocks(1);
        total++; if (pc !== {4'h0, mpc} || bus.data_out !== ma) begin
          bad++; $display("FAIL rnd_state n=%0d ir=%h pc=%h a=%h want %h/%h", n, ir, pc, bus.data_out, mpc, ma);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_ldi_jmpr();
    test_add_sta();
    test_jz_jnz();
    test_sta_io();
    test_halt();
    test_random(8, 150);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
